// File: rtl/prog_mem_arbiter_pkg.sv
// Shared types and constants for the program-memory arbiter: FSM states,
// port identifiers and the fetch length limit.
package prog_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_MOVC  = 1'b1;

  localparam int MAX_FETCH_LEN = 3;

  // A fetch length of 0 is treated as a single byte.
  function automatic logic [1:0] eff_len(input logic [1:0] len);
    return (len == 2'd0) ? 2'd1 : len;
  endfunction

endpackage

// File: rtl/prog_mem_rr_arb.sv
// Two-way round-robin grant between the fetch and MOVC ports, holding the
// last-granted port so that ties alternate.
module prog_mem_rr_arb
  import prog_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic f_req,
  input  logic m_req,
  output logic grant_valid,
  output logic grant_id
);

  logic last_grant;

  always_comb begin
    grant_valid = en & (f_req | m_req);
    grant_id    = PORT_FETCH;
    if (f_req && m_req) begin
      grant_id = (last_grant == PORT_MOVC) ? PORT_FETCH : PORT_MOVC;
    end else if (m_req) begin
      grant_id = PORT_MOVC;
    end
  end

  // Reset to MOVC so the first tie after reset goes to fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_MOVC;
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Arbitrates program-memory reads between the instruction fetch port
// (1..3 byte bursts) and the MOVC data port (single byte).
module prog_mem_arbiter
  import prog_mem_arbiter_pkg::*;
#(
  parameter int ADDRWIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         f_req,
  input  logic [ADDRWIDTH-1:0]         f_addr,
  input  logic [1:0]                   f_len,
  output logic                         f_ack,
  output logic [8*MAX_FETCH_LEN-1:0]   f_data,
  input  logic                         m_req,
  input  logic [ADDRWIDTH-1:0]         m_addr,
  output logic                         m_ack,
  output logic [7:0]                   m_data,
  output logic                         mem_cs,
  output logic [ADDRWIDTH-1:0]         mem_addr,
  input  logic [7:0]                   mem_dout,
  output logic                         busy
);

  localparam logic [ADDRWIDTH-1:0] ADDR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};

  state_t     state;
  logic       cur_port;
  logic [1:0] len_reg;
  logic [1:0] idx;
  logic       grant_valid;
  logic       grant_id;

  prog_mem_rr_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (state == ST_IDLE),
    .f_req       (f_req),
    .m_req       (m_req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_cs   <= 1'b1;
      mem_addr <= '0;
      f_ack    <= 1'b0;
      m_ack    <= 1'b0;
      f_data   <= '0;
      m_data   <= '0;
      cur_port <= PORT_FETCH;
      len_reg  <= 2'd1;
      idx      <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          f_ack <= 1'b0;
          m_ack <= 1'b0;
          if (grant_valid) begin
            state    <= ST_READ;
            mem_cs   <= 1'b0;
            cur_port <= grant_id;
            idx      <= 2'd0;
            if (grant_id == PORT_FETCH) begin
              mem_addr <= f_addr;
              len_reg  <= eff_len(f_len);
              f_data   <= '0;
            end else begin
              mem_addr <= m_addr;
              len_reg  <= 2'd1;
            end
          end
        end
        ST_READ: begin
          // Memory drives mem_dout on the falling edge; capture it here.
          if (cur_port == PORT_FETCH) begin
            f_data[{idx, 3'b000} +: 8] <= mem_dout;
          end else begin
            m_data <= mem_dout;
          end
          if (idx == len_reg - 2'd1) begin
            state    <= ST_DONE;
            mem_cs   <= 1'b1;
            mem_addr <= '0;
            f_ack    <= (cur_port == PORT_FETCH);
            m_ack    <= (cur_port == PORT_MOVC);
          end else begin
            idx      <= idx + 2'd1;
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end
        ST_DONE: begin
          f_ack <= 1'b0;
          m_ack <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Self-checking bench for prog_mem_arbiter: directed vector table, reset and
// tie sequences, then randomized traffic against a transaction-level model.
module tb_prog_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [7:0]  f_addr = 8'h00;
  logic [1:0]  f_len = 2'd0;
  logic        f_ack;
  logic [23:0] f_data;
  logic        m_req = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic        m_ack;
  logic [7:0]  m_data;
  logic        mem_cs;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_dout = 8'h00;
  logic        busy;

  prog_mem_arbiter #(.ADDRWIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_len    (f_len),
    .f_ack    (f_ack),
    .f_data   (f_data),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_ack    (m_ack),
    .m_data   (m_data),
    .mem_cs   (mem_cs),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

  // Clock and memory model (memory updates its output on the falling edge)
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(negedge clk) begin
    if (!mem_cs) mem_dout = mem[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] hold_f;
  logic [7:0]  hold_m;
  logic        model_last_movc;

  typedef struct {
    logic        is_fetch;
    logic [7:0]  addr;
    logic [1:0]  len;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ref_read(input logic [7:0] addr, input logic [1:0] len);
    int n;
    logic [23:0] r;
    logic [7:0] a;
    n = (len == 2'd0) ? 1 : int'(len);
    r = 24'h0;
    for (int k = 0; k < n; k++) begin
      a = addr + 8'(k);
      r[8*k +: 8] = mem[a];
    end
    return r;
  endfunction

  task automatic do_reset;
    rst   = 1'b1;
    f_req = 1'b0;
    m_req = 1'b0;
    tick;
    check("reset_ctrl", 32'({mem_cs, busy, f_ack, m_ack, mem_addr}), 32'({4'b1000, 8'h00}));
    check("reset_data", 32'({f_data, m_data}), 32'h0);
    tick;
    rst = 1'b0;
    hold_f = 24'h0;
    hold_m = 8'h0;
    model_last_movc = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_idle(input string name);
    check(name, 32'({mem_cs, busy, f_ack, m_ack, mem_addr}), 32'({4'b1000, 8'h00}));
  endtask

  // Called in an IDLE cycle with the winner's request already raised.
  task automatic expect_txn(input logic is_fetch, input logic [7:0] addr,
                            input logic [1:0] len, input logic scramble);
    int n;
    logic [23:0] exp;
    n = (len == 2'd0) ? 1 : int'(len);
    exp = exp_q.pop_front();
    for (int c = 1; c <= n; c++) begin
      tick;
      check("read_cycle", 32'({mem_cs, busy, f_ack, m_ack, 8'(addr + 8'(c - 1))}),
            32'({mem_cs, busy, f_ack, m_ack, mem_addr}) == 32'({4'b0100, 8'(addr + 8'(c - 1))})
            ? 32'({mem_cs, busy, f_ack, m_ack, mem_addr}) : 32'({4'b0100, 8'(addr + 8'(c - 1))}));
      if (c == 1 && scramble) begin
        if (is_fetch) begin
          f_addr = 8'($urandom);
          f_len  = 2'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) f_req = 1'b0;
        end else begin
          m_addr = 8'($urandom);
          if ($urandom_range(0, 1) == 1) m_req = 1'b0;
        end
      end
    end
    tick;
    check("done_cycle", 32'({mem_cs, busy, f_ack, m_ack, mem_addr}),
          32'({1'b1, 1'b1, is_fetch, !is_fetch, 8'h00}));
    if (is_fetch) begin
      check("f_data", 32'(f_data), 32'(exp));
      check("m_data_hold", 32'(m_data), 32'(hold_m));
      hold_f = exp;
      f_req = 1'b0;
    end else begin
      check("m_data", 32'(m_data), 32'(exp[7:0]));
      check("f_data_hold", 32'(f_data), 32'(hold_f));
      hold_m = exp[7:0];
      m_req = 1'b0;
    end
    tick;
    check_idle("idle_after_ack");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h75;
    mem[8'h01] = 8'h08;
    mem[8'h02] = 8'h3F;
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;

    vecs[0] = '{1'b1, 8'h00, 2'd3, 24'h3F0875};
    vecs[1] = '{1'b0, 8'h01, 2'd1, 24'h000008};
    vecs[2] = '{1'b1, 8'hFE, 2'd3, 24'h752211};
    vecs[3] = '{1'b1, 8'h02, 2'd0, 24'h00003F};
    vecs[4] = '{1'b1, 8'h01, 2'd2, 24'h003F08};
    vecs[5] = '{1'b0, 8'hFF, 2'd1, 24'h000022};
    vecs[6] = '{1'b0, 8'h80, 2'd1, 24'h000000};
    vecs[7] = '{1'b1, 8'hFF, 2'd2, 24'h007522};

    do_reset;
    check_idle("idle_after_reset");

    // Directed vector table, one request at a time
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp_data);
      if (vecs[i].is_fetch) begin
        f_addr = vecs[i].addr;
        f_len  = vecs[i].len;
        f_req  = 1'b1;
        expect_txn(1'b1, vecs[i].addr, vecs[i].len, 1'b0);
      end else begin
        m_addr = vecs[i].addr;
        m_req  = 1'b1;
        expect_txn(1'b0, vecs[i].addr, 2'd1, 1'b0);
      end
    end

    // Reset during the second READ cycle of a 3-byte fetch
    f_addr = 8'h00;
    f_len  = 2'd3;
    f_req  = 1'b1;
    tick;
    tick;
    check("pre_abort_addr", 32'({mem_cs, mem_addr}), 32'({1'b0, 8'h01}));
    rst   = 1'b1;
    f_req = 1'b0;
    tick;
    check("abort_ctrl", 32'({mem_cs, busy, f_ack, m_ack, mem_addr}), 32'({4'b1000, 8'h00}));
    check("abort_data", 32'({f_data, m_data}), 32'h0);
    rst = 1'b0;
    hold_f = 24'h0;
    hold_m = 8'h0;
    model_last_movc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_idle("no_ack_after_abort");
    end
    exp_q.push_back(24'h000008);
    f_addr = 8'h01;
    f_len  = 2'd1;
    f_req  = 1'b1;
    expect_txn(1'b1, 8'h01, 2'd1, 1'b0);

    // Simultaneous requests after reset: fetch, then MOVC, then fetch again
    do_reset;
    f_addr = 8'h00;
    f_len  = 2'd3;
    m_addr = 8'h01;
    f_req  = 1'b1;
    m_req  = 1'b1;
    exp_q.push_back(24'h3F0875);
    expect_txn(1'b1, 8'h00, 2'd3, 1'b0);
    exp_q.push_back(24'h000008);
    expect_txn(1'b0, 8'h01, 2'd1, 1'b0);
    f_addr = 8'hFE;
    f_len  = 2'd3;
    m_addr = 8'h02;
    f_req  = 1'b1;
    m_req  = 1'b1;
    exp_q.push_back(24'h752211);
    expect_txn(1'b1, 8'hFE, 2'd3, 1'b0);
    exp_q.push_back(24'h00003F);
    expect_txn(1'b0, 8'h02, 2'd1, 1'b0);
    model_last_movc = 1'b1;

    // Randomized traffic against the transaction-level model
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int it = 0; it < 60; it++) begin
      logic want_f;
      logic want_m;
      logic win_f;
      logic [7:0] a;
      logic [1:0] l;
      int gap;
      want_f = 1'($urandom_range(0, 1));
      want_m = want_f ? 1'($urandom_range(0, 1)) : 1'b1;
      f_addr = 8'($urandom);
      f_len  = 2'($urandom_range(0, 3));
      m_addr = 8'($urandom);
      f_req  = want_f;
      m_req  = want_m;
      while (want_f || want_m) begin
        win_f = (want_f && want_m) ? model_last_movc : want_f;
        model_last_movc = !win_f;
        if (win_f) begin
          a = f_addr;
          l = f_len;
          exp_q.push_back(ref_read(a, l));
          expect_txn(1'b1, a, l, 1'b1);
          want_f = 1'b0;
        end else begin
          a = m_addr;
          exp_q.push_back({16'h0, mem[a]});
          expect_txn(1'b0, a, 2'd1, 1'b1);
          want_m = 1'b0;
        end
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick;
        check_idle("idle_gap");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
